// File: rtl/sha256_job_arbiter.sv
// Round-robin arbiter that shares one simplified_sha256 core between NUM_REQ requesters,
// with a per-job watchdog that aborts and flags a core that never completes.
module sha256_job_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*16-1:0]      req_msg_addr,
    input  logic [NUM_REQ*16-1:0]      req_out_addr,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       cmp_valid,
    output logic [$clog2(NUM_REQ)-1:0] cmp_id,
    output logic                       cmp_err,
    output logic                       busy,
    output logic                       core_start,
    output logic [15:0]                core_message_addr,
    output logic [15:0]                core_output_addr,
    input  logic                       core_done
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH, DONE} state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] pick_id;
    logic [IDW-1:0] idx;
    logic           pick_valid;
    logic [WDW-1:0] wdog;
    logic           wdog_expired;

    assign wdog_expired = (wdog == WDW'(TIMEOUT - 1));

    // Scan starts just after the last winner so every requester is reached within NUM_REQ jobs.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((32'(rr_ptr) + k) % NUM_REQ);
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            rr_ptr            <= IDW'(NUM_REQ - 1);
            wdog              <= '0;
            grant             <= '0;
            cmp_valid         <= 1'b0;
            cmp_id            <= '0;
            cmp_err           <= 1'b0;
            busy              <= 1'b0;
            core_start        <= 1'b0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_done && pick_valid) begin
                        grant[pick_id]    <= 1'b1;
                        rr_ptr            <= pick_id;
                        cmp_id            <= pick_id;
                        core_message_addr <= req_msg_addr[16*pick_id +: 16];
                        core_output_addr  <= req_out_addr[16*pick_id +: 16];
                        core_start        <= 1'b1;
                        busy              <= 1'b1;
                        wdog              <= '0;
                        state             <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    grant <= '0;
                    if (wdog_expired) begin
                        core_start <= 1'b0;
                        cmp_valid  <= 1'b1;
                        cmp_err    <= 1'b1;
                        state      <= DONE;
                    end else begin
                        wdog <= wdog + WDW'(1);
                        // Start is held until the core acknowledges by dropping done.
                        if (!core_done) begin
                            core_start <= 1'b0;
                            state      <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (wdog_expired) begin
                        core_start <= 1'b0;
                        cmp_valid  <= 1'b1;
                        cmp_err    <= 1'b1;
                        state      <= DONE;
                    end else begin
                        wdog <= wdog + WDW'(1);
                        if (core_done) begin
                            cmp_valid <= 1'b1;
                            cmp_err   <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    cmp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Bench for sha256_job_arbiter: job-level reference model compared every cycle,
// directed timing pins, then randomized requesters and core latencies.
module tb_sha256_job_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 300;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*16-1:0]   req_msg_addr;
    logic [NREQ*16-1:0]   req_out_addr;
    logic [NREQ-1:0]      grant;
    logic                 cmp_valid;
    logic [IDW-1:0]       cmp_id;
    logic                 cmp_err;
    logic                 busy;
    logic                 core_start;
    logic [15:0]          core_message_addr;
    logic [15:0]          core_output_addr;
    logic                 core_done;

    always #5 clk = ~clk;

    sha256_job_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .req_msg_addr(req_msg_addr), .req_out_addr(req_out_addr),
        .grant(grant), .cmp_valid(cmp_valid), .cmp_id(cmp_id), .cmp_err(cmp_err),
        .busy(busy), .core_start(core_start),
        .core_message_addr(core_message_addr), .core_output_addr(core_output_addr),
        .core_done(core_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Core model: done drops one cycle after start is seen, stays low core_lat cycles.
    int   core_mode = 0;   // 0 normal, 1 done stuck high, 2 done held low
    int   core_lat  = 5;
    bit   rand_lat  = 0;
    bit   core_pend = 0;
    int   core_cnt  = 0;

    always @(posedge clk) begin
        #1;
        if (core_mode == 2) begin
            core_done = 1'b0; core_pend = 0; core_cnt = 0;
        end else if (core_mode == 1) begin
            core_done = 1'b1; core_pend = 0; core_cnt = 0;
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) core_done = 1'b1;
        end else if (core_pend) begin
            core_pend = 0;
            core_done = 1'b0;
            if (rand_lat)
                core_cnt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(295, 302))
                                                       : int'($urandom_range(1, 20));
            else
                core_cnt = core_lat;
        end else if (!core_done) begin
            core_done = 1'b1;
        end else if (core_start) begin
            core_pend = 1;
        end
    end

    // Requesters: drop req the cycle after grant; optionally raise new random jobs.
    bit auto_drop = 1;
    bit rand_req  = 0;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (auto_drop && grant[i]) begin
                req[i] = 1'b0;
            end else if (rand_req && !req[i] && $urandom_range(0, 3) == 0) begin
                req_msg_addr[16*i +: 16] = 16'($urandom);
                req_out_addr[16*i +: 16] = 16'($urandom);
                req[i] = 1'b1;
            end
        end
    end

    // Reference model: one job record with its grant time; outputs follow from event rules.
    logic [NREQ-1:0] e_grant;
    logic            e_cv, e_err, e_busy, e_start;
    logic [IDW-1:0]  e_id;
    logic [15:0]     e_maddr, e_oaddr;
    bit              m_job, m_seen_low, m_closing;
    int              m_t0, m_ptr, edge_n, w;

    task automatic model_close(input logic err);
        e_cv = 1'b1; e_err = err; e_start = 1'b0;
        m_job = 0; m_closing = 1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_grant = '0; e_cv = 0; e_err = 0; e_busy = 0; e_start = 0; e_id = '0;
            e_maddr = '0; e_oaddr = '0;
            m_job = 0; m_seen_low = 0; m_closing = 0; m_ptr = NREQ - 1; edge_n = 0; m_t0 = 0;
        end else begin
            edge_n++;
            e_grant = '0;
            if (m_closing) begin
                e_cv = 1'b0; e_busy = 1'b0; m_closing = 0;
            end else if (!m_job) begin
                if (core_done && req != '0) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        w = (m_ptr + k) % NREQ;
                        if (req[w]) begin
                            e_grant[w] = 1'b1;
                            m_ptr      = w;
                            e_id       = IDW'(w);
                            e_maddr    = req_msg_addr[16*w +: 16];
                            e_oaddr    = req_out_addr[16*w +: 16];
                            e_start    = 1'b1;
                            e_busy     = 1'b1;
                            m_job      = 1;
                            m_seen_low = 0;
                            m_t0       = edge_n;
                            break;
                        end
                    end
                end
            end else if (edge_n - m_t0 == TMO) begin
                model_close(1'b1);
            end else if (!m_seen_low) begin
                if (!core_done) begin
                    m_seen_low = 1;
                    e_start    = 1'b0;
                end
            end else if (core_done) begin
                model_close(1'b0);
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int glog[$];
    int cv_cnt = 0;

    always @(negedge clk) begin
        #1;
        check("grant", grant, e_grant);
        check("cmp_valid", cmp_valid, e_cv);
        check("cmp_id", cmp_id, e_id);
        if (e_cv || !reset_n) check("cmp_err", cmp_err, e_err);
        check("busy", busy, e_busy);
        check("core_start", core_start, e_start);
        check("core_message_addr", core_message_addr, e_maddr);
        check("core_output_addr", core_output_addr, e_oaddr);
        for (int i = 0; i < NREQ; i++) if (grant[i]) glog.push_back(i);
        if (cmp_valid) cv_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(input string name, input int lim);
        bit ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (grant != '0) begin ok = 1; break; end
        end
        check({name, "_grant_seen"}, 32'(ok), 1);
    endtask

    task automatic wait_cv(input string name, input int lim);
        bit ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (cmp_valid) begin ok = 1; break; end
        end
        check({name, "_cmp_seen"}, 32'(ok), 1);
    endtask

    task automatic wait_idle(input string name, input int lim);
        bit ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!busy && core_done) begin ok = 1; break; end
        end
        check({name, "_idle"}, 32'(ok), 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int g;
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int latb[2]   = '{297, 298};

    initial begin
        reset_n = 1'b0; req = '0; req_msg_addr = '0; req_out_addr = '0; core_done = 1'b1;
        cycles(3);
        check("rst_ctrl", {grant, cmp_valid, cmp_id, cmp_err, busy, core_start}, 0);
        check("rst_addr", {core_message_addr, core_output_addr}, 0);
        reset_n = 1'b1;
        cycles(1);
        check("rst_rel_ctrl", {grant, cmp_valid, cmp_id, cmp_err, busy, core_start}, 0);

        // First request after reset
        core_lat = 5;
        req_msg_addr[32 +: 16] = 16'h1234; req_out_addr[32 +: 16] = 16'h5678;
        req[2] = 1'b1;
        cycles(1);
        check("t1_grant", grant, 4'b0100);
        check("t1_start", core_start, 1);
        wait_cv("t1", 50);

        // Single job with a 200-cycle core
        core_lat = 200;
        req_msg_addr[16 +: 16] = 16'h0010; req_out_addr[16 +: 16] = 16'h0100;
        req[1] = 1'b1;
        wait_grant("t2", 20);
        g = cyc;
        check("t2_grant", grant, 4'b0010);
        check("t2_maddr", core_message_addr, 16'h0010);
        check("t2_oaddr", core_output_addr, 16'h0100);
        cycles(1);
        check("t2_start_held", core_start, 1);
        cycles(1);
        check("t2_start_drop", core_start, 0);
        wait_cv("t2", 260);
        check("t2_latency", 32'(cyc - g), 202);
        check("t2_id", cmp_id, 1);
        check("t2_err", cmp_err, 0);

        // Round robin with all requests held
        wait_idle("t3", 20);
        pulse_reset();
        core_lat = 3; auto_drop = 0;
        glog.delete();
        req = 4'b1111;
        for (int i = 0; i < 300 && glog.size() < 5; i++) @(negedge clk);
        check("t3_count", glog.size(), 5);
        for (int i = 0; i < 5 && i < glog.size(); i++) check("t3_order", glog[i], exp_rr[i]);
        req = '0; auto_drop = 1;
        wait_cv("t3", 50);

        // Core busy when a request arrives
        wait_idle("t4", 20);
        core_mode = 2;
        cycles(2);
        glog.delete();
        req[0] = 1'b1;
        cycles(10);
        check("t4_nogrant", glog.size(), 0);
        core_mode = 0;
        wait_grant("t4", 10);
        check("t4_grant", grant, 4'b0001);
        wait_cv("t4", 50);

        // Watchdog with done stuck high, then a normal job
        wait_idle("t5", 20);
        core_mode = 1;
        req_msg_addr[48 +: 16] = 16'hbeef;
        req[3] = 1'b1;
        wait_grant("t5", 10);
        g = cyc;
        wait_cv("t5", 400);
        check("t5_latency", 32'(cyc - g), TMO);
        check("t5_err", cmp_err, 1);
        check("t5_id", cmp_id, 3);
        core_mode = 0;
        cycles(2);
        req[2] = 1'b1;
        wait_grant("t5b", 10);
        check("t5b_grant", grant, 4'b0100);
        wait_cv("t5b", 50);
        check("t5b_err", cmp_err, 0);

        // Latencies straddling the watchdog: 298 collides with the timeout edge
        for (int j = 0; j < 2; j++) begin
            wait_idle("tb", 400);
            core_lat = latb[j];
            req[1] = 1'b1;
            wait_grant("tb", 10);
            g = cyc;
            wait_cv("tb", 400);
            check("tb_latency", 32'(cyc - g), (j == 0) ? 299 : 300);
            check("tb_err", cmp_err, (j == 0) ? 0 : 1);
        end

        // Reset while waiting for done to rise
        wait_idle("t6", 400);
        core_lat = 50;
        req[1] = 1'b1;
        wait_grant("t6", 10);
        cycles(5);
        reset_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_start", core_start, 0);
        @(negedge clk);
        reset_n = 1'b1;
        cv_cnt = 0;
        cycles(80);
        check("t6_no_cmp", cv_cnt, 0);

        // Randomized traffic
        rand_lat = 1; rand_req = 1;
        cycles(4000);
        rand_req = 0;
        cycles(5);
        wait_idle("rand", 800);
        cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end
endmodule
